cacheline_adapter: RTL and testbench

Converts one cache-line transfer into a multi-beat burst on the 64-bit physical memory port. Sits between `cache_top`'s line-wide memory side and the top-level `mem_*` pins. Reads gather N beats into one line and return it with a single-cycle response. Writes split a latched line into N beats.

---
 rtl/cacheline_adapter_pkg.sv | 17 +
 rtl/cacheline_adapter_if.sv | 35 +++
 rtl/cacheline_adapter.sv | 91 +++++++++
 tb/tb_cacheline_adapter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache-line <-> 64-bit memory burst adapter.
package cacheline_adapter_pkg;

  typedef logic [255:0] cacheline_t;
  typedef logic [63:0]  mem_beat_t;

  localparam int CACHELINE_BEATS       = 4;
  localparam int CACHELINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter_if.sv
// Line-side request/response and memory-side burst signals of the adapter.
interface cacheline_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  logic                  line_read;
  logic                  line_write;
  logic [31:0]           line_address;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [BEAT_WIDTH-1:0] mem_wdata;
  logic [BEAT_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  // Adapter side: serves line requests, masters the memory port.
  modport slave (
    input  line_read, line_write, line_address, line_wdata,
    output line_rdata, line_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // Cache/memory-model side.
  modport master (
    output line_read, line_write, line_address, line_wdata,
    input  line_rdata, line_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Turns one cache-line read/write into a BEATS-long burst on the memory port;
// read beats are gathered into line_rdata, write beats are sliced from a latched line.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adapter_if.slave  bus
);

  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_BYTES) - 32'd1);

  adapter_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d       = state_q;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.line_resp = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins if the upstream arbiter ever presents both.
        if (bus.line_write)     state_d = WRITE;
        else if (bus.line_read) state_d = READ;
      end
      READ: begin
        bus.mem_read = 1'b1;
        if (bus.mem_resp && last_beat) state_d = DONE;
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        if (bus.mem_resp && last_beat) state_d = DONE;
      end
      DONE: begin
        // Requests are not sampled here so the held request cannot re-trigger.
        bus.line_resp = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.line_write || bus.line_read) begin
            cnt_q  <= '0;
            addr_q <= bus.line_address;
            if (bus.line_write) wline_q <= bus.line_wdata;
          end
        end
        READ: begin
          if (bus.mem_resp) begin
            rdata_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rdata;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          if (bus.mem_resp) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_address = addr_q & ADDR_MASK;
  assign bus.mem_wdata   = wline_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];
  assign bus.line_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed plus randomized bench for cacheline_adapter, checked against a
// transaction-level model of line reads/writes split into 64-bit beats.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  cacheline_t last_rd = '0;

  cacheline_adapter_if #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) bus ();

  cacheline_adapter #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cacheline_t rand_line();
    cacheline_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_line_resp"}, 256'(bus.line_resp), 256'd0);
    check({tag, "_mem_read"},  256'(bus.mem_read),  256'd0);
    check({tag, "_mem_write"}, 256'(bus.mem_write), 256'd0);
    check({tag, "_mem_addr"},  256'(bus.mem_address), 256'd0);
    check({tag, "_mem_wdata"}, 256'(bus.mem_wdata), 256'd0);
    check({tag, "_rdata"},     bus.line_rdata, 256'd0);
  endtask

  // One line transaction. mode 0: resp every cycle, 1: random gaps, 2: resp on cycles set in mask.
  // lat returns the cycle (request cycle = 0) in which line_resp is expected.
  task automatic do_burst(input bit is_wr, input bit both, input logic [31:0] addr,
                          input cacheline_t line, input int mode, input logic [63:0] mask,
                          output int lat);
    int beats = 0;
    int cyc;
    bit resp;
    bus.line_write   = is_wr;
    bus.line_read    = !is_wr || both;
    bus.line_address = addr;
    bus.line_wdata   = is_wr ? line : rand_line();
    bus.mem_resp     = 1'b0;
    check("idle_mem_read",  256'(bus.mem_read),  256'd0);
    check("idle_mem_write", 256'(bus.mem_write), 256'd0);
    tick();
    bus.line_wdata = rand_line();
    cyc = 1;
    while (beats < 4 && cyc < 64) begin
      case (mode)
        0:       resp = 1'b1;
        1:       resp = ($urandom_range(0, 1) == 1) || (cyc > 40);
        default: resp = mask[cyc];
      endcase
      bus.mem_resp  = resp;
      bus.mem_rdata = is_wr ? 64'($urandom) : line[beats*64 +: 64];
      check("burst_mem_read",  256'(bus.mem_read),  256'(!is_wr));
      check("burst_mem_write", 256'(bus.mem_write), 256'(is_wr));
      check("burst_mem_addr",  256'(bus.mem_address), 256'(addr & 32'hFFFF_FFE0));
      check("burst_line_resp", 256'(bus.line_resp), 256'd0);
      if (is_wr) check("burst_mem_wdata", 256'(bus.mem_wdata), 256'(line[beats*64 +: 64]));
      tick();
      if (resp) beats++;
      cyc++;
    end
    lat = cyc;
    if (beats < 4) begin
      check("burst_timeout_beats", 256'(beats), 256'd4);
    end else begin
      bus.mem_resp = 1'($urandom_range(0, 1));
      if (!is_wr) last_rd = line;
      check("done_line_resp", 256'(bus.line_resp), 256'd1);
      check("done_rdata",     bus.line_rdata, last_rd);
      check("done_mem_read",  256'(bus.mem_read),  256'd0);
      check("done_mem_write", 256'(bus.mem_write), 256'd0);
      tick();
    end
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.mem_resp   = 1'b0;
    check("after_line_resp", 256'(bus.line_resp), 256'd0);
    check("after_mem_read",  256'(bus.mem_read),  256'd0);
    check("after_mem_write", 256'(bus.mem_write), 256'd0);
  endtask

  initial begin
    int lat;
    cacheline_t rd_line, wr_line;
    bit wr;

    bus.line_read = 1'b1;
    bus.line_write = 1'b0;
    bus.line_address = 32'h0000_1234;
    bus.line_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    bus.line_read = 1'b0;
    bus.mem_resp = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Read with no gaps.
    rd_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_burst(1'b0, 1'b0, 32'h0000_1234, rd_line, 0, 64'd0, lat);
    check("read_latency", 256'(lat), 256'd5);

    // Write with responses on cycles 1, 3, 4, 7.
    wr_line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_burst(1'b1, 1'b0, 32'h0000_8040, wr_line, 2, 64'h9A, lat);
    check("write_gap_latency", 256'(lat), 256'd8);

    // Both requests at once: write must win.
    do_burst(1'b1, 1'b1, 32'hABCD_EF17, rand_line(), 1, 64'd0, lat);

    // Stray responses in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 64'($urandom);
      tick();
      check("stray_line_resp", 256'(bus.line_resp), 256'd0);
      check("stray_mem_read",  256'(bus.mem_read),  256'd0);
      check("stray_mem_write", 256'(bus.mem_write), 256'd0);
    end
    bus.mem_resp = 1'b0;
    do_burst(1'b0, 1'b0, 32'h0000_2000, rand_line(), 0, 64'd0, lat);
    check("stray_then_read_latency", 256'(lat), 256'd5);

    // Reset after two beats of a read.
    bus.line_read = 1'b1;
    bus.line_address = 32'h1111_0000;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.mem_resp = 1'b1;
      bus.mem_rdata = 64'($urandom);
      tick();
    end
    bus.mem_resp = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    last_rd = '0;
    bus.line_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_no_resp", 256'(bus.line_resp), 256'd0);
    end
    rst = 1'b1;
    tick();
    check("midreset_released_resp", 256'(bus.line_resp), 256'd0);
    do_burst(1'b0, 1'b0, 32'h1111_0000, rand_line(), 1, 64'd0, lat);

    // Back-to-back and random traffic; each call starts in the first IDLE cycle.
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      do_burst(wr, wr && ($urandom_range(0, 3) == 0), $urandom, rand_line(),
               (i < 4) ? 0 : 1, 64'd0, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
